// File: rtl/song_sequencer.sv
// Walks a song's event list in an external synchronous ROM and feeds the three-voice chord player.
// Emits note loads (strobe + note + duration) per chord and counts beats on wait events.
module song_sequencer #(
  parameter int SONG_BITS  = 2,
  parameter int IDX_BITS   = 5,
  parameter int MAX_VOICES = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic [SONG_BITS-1:0]          song,
  input  logic                          beat,
  input  logic                          note_done,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [15:0]                   rom_data,
  output logic [5:0]                    note_to_load,
  output logic [5:0]                    duration,
  output logic                          load_new_note,
  output logic                          song_done,
  output logic                          chord_overflow
);

  localparam int CW = $clog2(MAX_VOICES + 1);
  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {S_FETCH, S_DATA, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [SONG_BITS-1:0]  song_q, song_d;
  logic [5:0]            wait_cnt_q, wait_cnt_d;
  logic [CW-1:0]         chord_cnt_q, chord_cnt_d;
  logic [5:0]            note_q, note_d;
  logic [5:0]            dur_q, dur_d;
  logic                  ovf_q, ovf_d;

  logic                  song_change;
  logic                  at_last;
  state_t                adv_state;
  logic [IDX_BITS-1:0]   adv_idx;
  logic                  ev_is_wait;
  logic [5:0]            ev_note;
  logic [5:0]            ev_len;
  logic                  unused_rom_bits;

  assign song_change = (song != song_q);
  assign ev_is_wait  = rom_data[15];
  assign ev_note     = rom_data[14:9];
  assign ev_len      = rom_data[8:3];
  assign unused_rom_bits = ^rom_data[2:0];

  // Advancing past the last slot parks in DONE so the index never leaks into the next song.
  assign at_last   = (idx_q == IDX_LAST);
  assign adv_state = at_last ? S_DONE : S_FETCH;
  assign adv_idx   = at_last ? idx_q : idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    song_d      = song_q;
    wait_cnt_d  = wait_cnt_q;
    chord_cnt_d = chord_cnt_q;
    note_d      = note_q;
    dur_d       = dur_q;
    ovf_d       = ovf_q;

    if (song_change) begin
      song_d      = song;
      idx_d       = '0;
      state_d     = S_FETCH;
      wait_cnt_d  = '0;
      chord_cnt_d = '0;
      ovf_d       = 1'b0;
    end else if (play) begin
      unique case (state_q)
        S_FETCH: state_d = S_DATA;
        S_DATA: begin
          if (ev_is_wait) begin
            if (ev_len == 6'd0) begin
              state_d = S_DONE;
            end else begin
              state_d     = S_WAIT;
              wait_cnt_d  = ev_len;
              chord_cnt_d = '0;
            end
          end else if (ev_note == 6'd0) begin
            state_d = adv_state;
            idx_d   = adv_idx;
          end else if (chord_cnt_q >= CW'(MAX_VOICES)) begin
            state_d = adv_state;
            idx_d   = adv_idx;
            ovf_d   = 1'b1;
          end else begin
            note_d  = ev_note;
            dur_d   = ev_len;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          chord_cnt_d = chord_cnt_q + CW'(1);
          state_d     = adv_state;
          idx_d       = adv_idx;
        end
        S_WAIT: begin
          if (beat) begin
            if (wait_cnt_q == 6'd1) begin
              state_d = adv_state;
              idx_d   = adv_idx;
            end else begin
              wait_cnt_d = wait_cnt_q - 6'd1;
            end
          end
        end
        S_DONE: state_d = S_DONE;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      idx_q       <= '0;
      song_q      <= song;
      wait_cnt_q  <= '0;
      chord_cnt_q <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      song_q      <= song_d;
      wait_cnt_q  <= wait_cnt_d;
      chord_cnt_q <= chord_cnt_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      ovf_q       <= ovf_d;
    end
  end

  assign rom_addr       = {song_q, idx_q};
  assign note_to_load   = note_q;
  assign duration       = dur_q;
  assign load_new_note  = (state_q == S_ISSUE) && play && !song_change;
  assign song_done      = (state_q == S_DONE) && note_done;
  assign chord_overflow = ovf_q;

endmodule
